// File: rtl/rotary_input_ctrl_pkg.sv
// rtl/rotary_input_ctrl_pkg.sv - shared mode constants and the position accumulate helper
package rotary_input_ctrl_pkg;

   localparam int MODE_WRAP  = 0;
   localparam int MODE_CLAMP = 1;

   // pos is an unsigned w-bit position, delta is signed; result is again a w-bit position.
   function automatic int sat_add(input int pos, input int delta, input int clamp, input int w);
      int sum;
      int max_pos;
      max_pos = (1 << w) - 1;
      sum     = pos + delta;
      if (clamp != MODE_WRAP) begin
         if (sum < 0)            sat_add = 0;
         else if (sum > max_pos) sat_add = max_pos;
         else                    sat_add = sum;
      end else begin
         sat_add = sum & max_pos;
      end
   endfunction

endpackage

// File: rtl/rotary_input_ctrl_if.sv
// rtl/rotary_input_ctrl_if.sv - button/spinner inputs and per-channel position outputs
interface rotary_input_ctrl_if #(
   parameter int N_CH    = 2,
   parameter int ANGLE_W = 4
);
   logic                    strobe;
   logic [N_CH-1:0]         fast;
   logic [N_CH-1:0]         minus;
   logic [N_CH-1:0]         plus;
   logic [N_CH-1:0]         preset;
   logic [N_CH*9-1:0]       spin_in;
   logic [N_CH*ANGLE_W-1:0] angle_out;
   logic [N_CH-1:0]         moved;

   modport master (
      output strobe, fast, minus, plus, preset, spin_in,
      input  angle_out, moved
   );

   modport slave (
      input  strobe, fast, minus, plus, preset, spin_in,
      output angle_out, moved
   );
endinterface

// File: rtl/rotary_input_ctrl_channel.sv
// rtl/rotary_input_ctrl_channel.sv - one channel: repeat counter, toggle detect, accumulator
module rotary_input_ctrl_channel
   import rotary_input_ctrl_pkg::*;
#(
   parameter int ANGLE_W    = 4,
   parameter int FRAC_W     = 2,
   parameter int STEP_SLOW  = 8,
   parameter int STEP_FAST  = 2,
   parameter int CLAMP      = MODE_WRAP,
   parameter int INIT_ANGLE = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stb_edge,
   input  logic               fast,
   input  logic               minus,
   input  logic               plus,
   input  logic               preset,
   input  logic [8:0]         spin_in,
   output logic [ANGLE_W-1:0] angle_out,
   output logic               moved
);
   localparam int POS_W    = ANGLE_W + FRAC_W;
   localparam int STEP_MAX = (STEP_SLOW > STEP_FAST) ? STEP_SLOW : STEP_FAST;
   localparam int CNT_W    = (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1;
   localparam logic [POS_W-1:0] INIT_POS = POS_W'(INIT_ANGLE << FRAC_W);

   logic [POS_W-1:0] pos_q, pos_d;
   logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
   logic             tog_q, tog_d;
   logic             moved_q, moved_d;
   int               period;
   int               delta;

   always_comb begin
      period    = fast ? STEP_FAST : STEP_SLOW;
      delta     = 0;
      rep_cnt_d = rep_cnt_q;
      tog_d     = spin_in[8];

      if (plus == minus) begin
         rep_cnt_d = '0;
      end else if (stb_edge) begin
         if (rep_cnt_q == '0) delta = plus ? (1 << FRAC_W) : -(1 << FRAC_W);
         // >= so a switch to a shorter period mid-hold wraps instead of stalling
         rep_cnt_d = (int'(rep_cnt_q) >= period - 1) ? '0 : rep_cnt_q + CNT_W'(1);
      end

      if (spin_in[8] != tog_q) delta = delta + int'($signed(spin_in[7:0]));

      pos_d = POS_W'(sat_add(int'(pos_q), delta, CLAMP, POS_W));
      if (preset) begin
         pos_d     = INIT_POS;
         rep_cnt_d = '0;
      end

      moved_d = (pos_d[POS_W-1:FRAC_W] != pos_q[POS_W-1:FRAC_W]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pos_q     <= INIT_POS;
         rep_cnt_q <= '0;
         tog_q     <= spin_in[8];
         moved_q   <= 1'b0;
      end else begin
         pos_q     <= pos_d;
         rep_cnt_q <= rep_cnt_d;
         tog_q     <= tog_d;
         moved_q   <= moved_d;
      end
   end

   assign angle_out = pos_q[POS_W-1:FRAC_W];
   assign moved     = moved_q;

endmodule

// File: rtl/rotary_input_ctrl.sv
// rtl/rotary_input_ctrl.sv - multi-channel digital/analog rotary position controller
module rotary_input_ctrl
   import rotary_input_ctrl_pkg::*;
#(
   parameter int N_CH       = 2,
   parameter int ANGLE_W    = 4,
   parameter int FRAC_W     = 2,
   parameter int STEP_SLOW  = 8,
   parameter int STEP_FAST  = 2,
   parameter int CLAMP      = MODE_WRAP,
   parameter int INIT_ANGLE = 0
) (
   input  logic                clk,
   input  logic                reset,
   rotary_input_ctrl_if.slave  io
);
   logic stb_prev_q, stb_prev_d;
   logic stb_edge;

   always_comb begin
      stb_prev_d = io.strobe;
      stb_edge   = io.strobe & ~stb_prev_q;
   end

   // Reloading from the live strobe level also covers reset: no edge is seen on release.
   always_ff @(posedge clk) begin
      stb_prev_q <= stb_prev_d;
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      rotary_input_ctrl_channel #(
         .ANGLE_W    (ANGLE_W),
         .FRAC_W     (FRAC_W),
         .STEP_SLOW  (STEP_SLOW),
         .STEP_FAST  (STEP_FAST),
         .CLAMP      (CLAMP),
         .INIT_ANGLE (INIT_ANGLE)
      ) u_ch (
         .clk       (clk),
         .reset     (reset),
         .stb_edge  (stb_edge),
         .fast      (io.fast[g]),
         .minus     (io.minus[g]),
         .plus      (io.plus[g]),
         .preset    (io.preset[g]),
         .spin_in   (io.spin_in[g*9 +: 9]),
         .angle_out (io.angle_out[g*ANGLE_W +: ANGLE_W]),
         .moved     (io.moved[g])
      );
   end

endmodule

// File: tb/tb_rotary_input_ctrl.sv
// tb/tb_rotary_input_ctrl.sv - table, directed and random checks of wrap and clamp instances
module tb_rotary_input_ctrl;
   import rotary_input_ctrl_pkg::*;

   localparam int N_CH       = 2;
   localparam int ANGLE_W    = 4;
   localparam int FRAC_W     = 2;
   localparam int STEP_SLOW  = 8;
   localparam int STEP_FAST  = 2;
   localparam int INIT_ANGLE = 0;
   localparam int POS_MAX    = (1 << (ANGLE_W + FRAC_W)) - 1;
   localparam int STEP       = 1 << FRAC_W;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   rotary_input_ctrl_if #(.N_CH(N_CH), .ANGLE_W(ANGLE_W)) io_w ();
   rotary_input_ctrl_if #(.N_CH(N_CH), .ANGLE_W(ANGLE_W)) io_c ();

   assign io_c.strobe  = io_w.strobe;
   assign io_c.fast    = io_w.fast;
   assign io_c.minus   = io_w.minus;
   assign io_c.plus    = io_w.plus;
   assign io_c.preset  = io_w.preset;
   assign io_c.spin_in = io_w.spin_in;

   rotary_input_ctrl #(
      .N_CH(N_CH), .ANGLE_W(ANGLE_W), .FRAC_W(FRAC_W), .STEP_SLOW(STEP_SLOW),
      .STEP_FAST(STEP_FAST), .CLAMP(MODE_WRAP), .INIT_ANGLE(INIT_ANGLE)
   ) dut_w (.clk(clk), .reset(reset), .io(io_w));

   rotary_input_ctrl #(
      .N_CH(N_CH), .ANGLE_W(ANGLE_W), .FRAC_W(FRAC_W), .STEP_SLOW(STEP_SLOW),
      .STEP_FAST(STEP_FAST), .CLAMP(MODE_CLAMP), .INIT_ANGLE(INIT_ANGLE)
   ) dut_c (.clk(clk), .reset(reset), .io(io_c));

   // reference model: index [0] = wrap instance, [1] = clamp instance
   int m_pos [2][N_CH];
   int m_mv  [2][N_CH];
   int m_cnt [N_CH];
   bit m_tog [N_CH];
   bit m_stb_prev;

   int n_cmp  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;
   int mv_seen_w, mv_seen_c;

   typedef struct {
      bit [1:0]   plus, minus, fast, preset, tog_ch;
      logic [7:0] delta;
      int         n_tog, n_stb;
      int         a0_w, a1_w, a0_c, a1_c, mv0_w, mv0_c;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string name, input logic [31:0] act, input int exp);
      n_cmp++;
      if (act !== 32'(exp)) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int fold(input int s, input bit clamp);
      if (clamp) return (s < 0) ? 0 : ((s > POS_MAX) ? POS_MAX : s);
      return ((s % (POS_MAX + 1)) + POS_MAX + 1) % (POS_MAX + 1);
   endfunction

   task automatic model_step();
      bit stb;
      stb = io_w.strobe && !m_stb_prev;
      for (int ch = 0; ch < N_CH; ch++) begin
         int d;
         int per;
         int old;
         logic [8:0] sp;
         sp = io_w.spin_in[ch*9 +: 9];
         d  = 0;
         if (reset) begin
            for (int m = 0; m < 2; m++) begin
               m_pos[m][ch] = INIT_ANGLE * STEP;
               m_mv[m][ch]  = 0;
            end
            m_cnt[ch] = 0;
            m_tog[ch] = sp[8];
         end else begin
            if (io_w.plus[ch] == io_w.minus[ch]) begin
               m_cnt[ch] = 0;
            end else if (stb) begin
               if (m_cnt[ch] == 0) d = io_w.plus[ch] ? STEP : -STEP;
               per = io_w.fast[ch] ? STEP_FAST : STEP_SLOW;
               m_cnt[ch] = (m_cnt[ch] >= per - 1) ? 0 : m_cnt[ch] + 1;
            end
            if (sp[8] != m_tog[ch]) d += int'($signed(sp[7:0]));
            m_tog[ch] = sp[8];
            if (io_w.preset[ch]) m_cnt[ch] = 0;
            for (int m = 0; m < 2; m++) begin
               old = m_pos[m][ch];
               m_pos[m][ch] = io_w.preset[ch] ? INIT_ANGLE * STEP : fold(old + d, m == 1);
               m_mv[m][ch]  = ((old / STEP) != (m_pos[m][ch] / STEP)) ? 1 : 0;
            end
         end
      end
      m_stb_prev = io_w.strobe;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (chk_en) begin
         for (int ch = 0; ch < N_CH; ch++) begin
            chk($sformatf("model angle_w[%0d]", ch), 32'(io_w.angle_out[ch*ANGLE_W +: ANGLE_W]), m_pos[0][ch] / STEP);
            chk($sformatf("model angle_c[%0d]", ch), 32'(io_c.angle_out[ch*ANGLE_W +: ANGLE_W]), m_pos[1][ch] / STEP);
            chk($sformatf("model moved_w[%0d]", ch), 32'(io_w.moved[ch]), m_mv[0][ch]);
            chk($sformatf("model moved_c[%0d]", ch), 32'(io_c.moved[ch]), m_mv[1][ch]);
         end
      end
      mv_seen_w += int'(io_w.moved[0]);
      mv_seen_c += int'(io_c.moved[0]);
   endtask

   task automatic strobe_pulse();
      io_w.strobe = 1'b1;
      tick();
      io_w.strobe = 1'b0;
      tick();
   endtask

   task automatic flip_tog(input int ch, input logic [7:0] delta);
      io_w.spin_in[ch*9 +: 8] = delta;
      io_w.spin_in[ch*9 + 8]  = ~io_w.spin_in[ch*9 + 8];
   endtask

   task automatic apply_vec(input int idx, input vec_t v);
      mv_seen_w = 0;
      mv_seen_c = 0;
      io_w.plus  = v.plus;
      io_w.minus = v.minus;
      io_w.fast  = v.fast;
      for (int ch = 0; ch < N_CH; ch++)
         if (v.tog_ch[ch]) io_w.spin_in[ch*9 +: 8] = v.delta;
      if (v.preset != 2'b00) begin
         io_w.preset = v.preset;
         tick();
         io_w.preset = 2'b00;
      end
      for (int t = 0; t < v.n_tog; t++) begin
         for (int ch = 0; ch < N_CH; ch++)
            if (v.tog_ch[ch]) flip_tog(ch, v.delta);
         tick();
      end
      for (int s = 0; s < v.n_stb; s++) strobe_pulse();
      tick();
      chk($sformatf("vec%0d a0_w", idx), 32'(io_w.angle_out[0 +: ANGLE_W]), v.a0_w);
      chk($sformatf("vec%0d a1_w", idx), 32'(io_w.angle_out[ANGLE_W +: ANGLE_W]), v.a1_w);
      chk($sformatf("vec%0d a0_c", idx), 32'(io_c.angle_out[0 +: ANGLE_W]), v.a0_c);
      chk($sformatf("vec%0d a1_c", idx), 32'(io_c.angle_out[ANGLE_W +: ANGLE_W]), v.a1_c);
      chk($sformatf("vec%0d moved0_w count", idx), 32'(mv_seen_w), v.mv0_w);
      chk($sformatf("vec%0d moved0_c count", idx), 32'(mv_seen_c), v.mv0_c);
   endtask

   task automatic clear_all();
      io_w.plus   = 2'b00;
      io_w.minus  = 2'b00;
      io_w.fast   = 2'b00;
      io_w.preset = 2'b11;
      tick();
      io_w.preset = 2'b00;
      tick();
   endtask

   initial begin
      //            plus   minus  fast   preset tog_ch delta  ntog nstb a0w a1w a0c a1c mvw mvc
      vecs[0]  = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 0,  17,  3,  0,  3,  0,  3,  3};
      vecs[1]  = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 8'h00, 0,  0,   0,  0,  0,  0,  1,  1};
      vecs[2]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 8'd60, 1,  0,   15, 0,  15, 0,  1,  1};
      vecs[3]  = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 0,  1,   0,  0,  15, 0,  1,  0};
      vecs[4]  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 8'h00, 0,  0,   0,  0,  0,  0,  0,  1};
      vecs[5]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 8'h03, 4,  0,   0,  3,  0,  3,  0,  0};
      vecs[6]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 8'hFF, 1,  0,   0,  2,  0,  2,  0,  0};
      vecs[7]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 8'h40, 0,  0,   0,  2,  0,  2,  0,  0};
      vecs[8]  = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 8'h00, 0,  10,  0,  2,  0,  2,  0,  0};
      vecs[9]  = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 8'h00, 0,  1,   15, 2,  0,  2,  1,  0};
      vecs[10] = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 8'h00, 0,  0,   0,  0,  0,  0,  1,  0};

      reset        = 1'b1;
      io_w.strobe  = 1'b0;
      io_w.plus    = '0;
      io_w.minus   = '0;
      io_w.fast    = '0;
      io_w.preset  = '0;
      io_w.spin_in = '0;
      tick();
      tick();
      for (int ch = 0; ch < N_CH; ch++) begin
         chk($sformatf("reset angle_w[%0d]", ch), 32'(io_w.angle_out[ch*ANGLE_W +: ANGLE_W]), INIT_ANGLE);
         chk($sformatf("reset angle_c[%0d]", ch), 32'(io_c.angle_out[ch*ANGLE_W +: ANGLE_W]), INIT_ANGLE);
         chk($sformatf("reset moved_w[%0d]", ch), 32'(io_w.moved[ch]), 0);
      end
      reset  = 1'b0;
      chk_en = 1'b1;
      tick();

      for (int i = 0; i < 11; i++) apply_vec(i, vecs[i]);

      // digital step and analog delta landing on the same strobe edge
      io_w.plus[0] = 1'b1;
      io_w.strobe  = 1'b1;
      flip_tog(0, 8'd4);
      tick();
      chk("same-cycle angle_w", 32'(io_w.angle_out[0 +: ANGLE_W]), 2);
      chk("same-cycle angle_c", 32'(io_c.angle_out[0 +: ANGLE_W]), 2);
      chk("same-cycle moved_w", 32'(io_w.moved[0]), 1);
      io_w.strobe = 1'b0;
      tick();
      chk("same-cycle moved drop", 32'(io_w.moved[0]), 0);
      clear_all();

      // switching to fast mid-hold with the counter above the fast period
      io_w.plus[0] = 1'b1;
      for (int s = 0; s < 5; s++) strobe_pulse();
      chk("fast-switch pre angle", 32'(io_w.angle_out[0 +: ANGLE_W]), 1);
      io_w.fast[0] = 1'b1;
      strobe_pulse();
      chk("fast-switch wrap angle", 32'(io_w.angle_out[0 +: ANGLE_W]), 1);
      strobe_pulse();
      chk("fast-switch step angle", 32'(io_w.angle_out[0 +: ANGLE_W]), 2);
      clear_all();

      // reset mid-hold with a spinner toggle in the same cycle
      io_w.plus[0] = 1'b1;
      for (int s = 0; s < 3; s++) strobe_pulse();
      io_w.plus[0] = 1'b0;
      reset        = 1'b1;
      io_w.strobe  = 1'b1;
      flip_tog(0, 8'd5);
      tick();
      reset       = 1'b0;
      io_w.strobe = 1'b0;
      tick();
      chk("reset-mid angle", 32'(io_w.angle_out[0 +: ANGLE_W]), INIT_ANGLE);
      chk("reset-mid moved", 32'(io_w.moved[0]), 0);
      for (int t = 0; t < 3; t++) tick();
      chk("post-reset no delta", 32'(io_w.angle_out[0 +: ANGLE_W]), INIT_ANGLE);
      flip_tog(0, 8'd5);
      tick();
      chk("post-reset real toggle", 32'(io_w.angle_out[0 +: ANGLE_W]), INIT_ANGLE + 1);
      clear_all();

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) io_w.strobe = ~io_w.strobe;
         for (int ch = 0; ch < N_CH; ch++) begin
            if ($urandom_range(0, 31) == 0) io_w.plus[ch]  = 1'($urandom);
            if ($urandom_range(0, 31) == 0) io_w.minus[ch] = 1'($urandom);
            if ($urandom_range(0, 63) == 0) io_w.fast[ch]  = 1'($urandom);
            io_w.preset[ch] = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 7) == 0) flip_tog(ch, 8'($urandom));
            else if ($urandom_range(0, 15) == 0) io_w.spin_in[ch*9 +: 8] = 8'($urandom);
         end
         reset = ($urandom_range(0, 499) == 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
